// File: rtl/pulse_seq_pkg.sv
// Shared definitions for the pulse sequencer: state encoding and default counter width.
package pulse_seq_pkg;

    // Default width of every timing field, the repetition count and the pulse index.
    localparam int unsigned CNT_WIDTH_DEFAULT = 16;

    // Sequencer state encoding.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_DELAY = 3'd1;
    localparam state_t ST_HIGH  = 3'd2;
    localparam state_t ST_GAP   = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with a zero flag. Decrement saturates at zero; load wins over decrement.
module seq_down_counter
    import pulse_seq_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] load_val_i,
    input  logic                 dec_i,
    output logic                 zero_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Next count: load, else decrement while non-zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_sequencer.sv
// Pulse sequencer: after start, waits cfg_delay cycles, then emits cfg_count pulses of
// cfg_width high cycles separated by max(cfg_gap,1) low cycles, then strobes done.
// Optional macro PULSE_SEQ_FREERUN_EN: a latched count of zero runs pulses until abort/rst.
module pulse_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] cfg_delay,
    input  logic [CNT_WIDTH-1:0] cfg_width,
    input  logic [CNT_WIDTH-1:0] cfg_gap,
    input  logic [CNT_WIDTH-1:0] cfg_count,
    output logic                 pulse_out,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] pulse_idx
);

`ifdef PULSE_SEQ_FREERUN_EN
    localparam bit FreeRunEn = 1'b1;
`else
    localparam bit FreeRunEn = 1'b0;
`endif

    localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    // Width and gap are re-used for every pulse; delay and count go straight into the counters.
    logic [CNT_WIDTH-1:0] width_q, width_d;
    logic [CNT_WIDTH-1:0] gap_q, gap_d;
    logic                 freerun_q, freerun_d;
    logic [CNT_WIDTH-1:0] idx_q, idx_d;
    logic                 pulse_q, busy_q, done_q;

    logic                 tmr_load, tmr_dec, tmr_zero;
    logic [CNT_WIDTH-1:0] tmr_val;
    logic                 rem_load, rem_dec, rem_zero;
    logic [CNT_WIDTH-1:0] rem_val;

    logic                 accept;
    logic                 no_pulse;
    logic                 last_pulse;
    logic [CNT_WIDTH-1:0] gap_len_m1;

    assign accept     = (state_q == ST_IDLE) && start && !abort;
    assign no_pulse   = (cfg_width == '0) || ((cfg_count == '0) && !FreeRunEn);
    assign last_pulse = rem_zero && !freerun_q;
    // A zero gap still leaves one low cycle so consecutive pulses stay distinct.
    assign gap_len_m1 = (gap_q == '0) ? '0 : (gap_q - CntOne);

    // Phase timer: counts the remaining cycles of DELAY, HIGH or GAP.
    seq_down_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_phase_tmr (
        .clk_in     (clk_in),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    // Remaining-pulse counter: holds pulses still to go after the current one.
    seq_down_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_remain_cnt (
        .clk_in     (clk_in),
        .rst        (rst),
        .load_i     (rem_load),
        .load_val_i (rem_val),
        .dec_i      (rem_dec),
        .zero_o     (rem_zero)
    );

    // Next-state logic, counter control and config capture.
    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        gap_d     = gap_q;
        freerun_d = freerun_q;
        idx_d     = idx_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_dec   = 1'b0;
        rem_load  = 1'b0;
        rem_val   = '0;
        rem_dec   = 1'b0;

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        width_d   = cfg_width;
                        gap_d     = cfg_gap;
                        freerun_d = FreeRunEn && (cfg_count == '0);
                        idx_d     = '0;
                        rem_load  = 1'b1;
                        rem_val   = cfg_count - CntOne;
                        if (no_pulse) begin
                            state_d = ST_DONE;
                        end else if (cfg_delay != '0) begin
                            state_d  = ST_DELAY;
                            tmr_load = 1'b1;
                            tmr_val  = cfg_delay - CntOne;
                        end else begin
                            state_d  = ST_HIGH;
                            tmr_load = 1'b1;
                            tmr_val  = cfg_width - CntOne;
                        end
                    end
                end
                ST_DELAY: begin
                    if (tmr_zero) begin
                        state_d  = ST_HIGH;
                        tmr_load = 1'b1;
                        tmr_val  = width_q - CntOne;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!tmr_zero) begin
                        tmr_dec = 1'b1;
                    end else if (last_pulse) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_GAP;
                        tmr_load = 1'b1;
                        tmr_val  = gap_len_m1;
                        rem_dec  = !freerun_q;
                    end
                end
                ST_GAP: begin
                    if (tmr_zero) begin
                        state_d  = ST_HIGH;
                        tmr_load = 1'b1;
                        tmr_val  = width_q - CntOne;
                        idx_d    = idx_q + CntOne;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, latched config and registered outputs; outputs decode the next state.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            width_q   <= '0;
            gap_q     <= '0;
            freerun_q <= 1'b0;
            idx_q     <= '0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            gap_q     <= gap_d;
            freerun_q <= freerun_d;
            idx_q     <= idx_d;
            pulse_q   <= (state_d == ST_HIGH);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pulse_idx = idx_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Self-checking bench for pulse_sequencer (CNT_WIDTH=4 so all-ones fields stay short).
module tb_pulse_sequencer;

    localparam int W = 4;

    logic         clk_in = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] cfg_delay = '0;
    logic [W-1:0] cfg_width = '0;
    logic [W-1:0] cfg_gap = '0;
    logic [W-1:0] cfg_count = '0;
    logic         pulse_out, busy, done;
    logic [W-1:0] pulse_idx;

    pulse_sequencer #(.CNT_WIDTH(W)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .cfg_delay (cfg_delay),
        .cfg_width (cfg_width),
        .cfg_gap   (cfg_gap),
        .cfg_count (cfg_count),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done),
        .pulse_idx (pulse_idx)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int pulse;
        int busy;
        int done;
        int idx;
    } exp_t;

    // Inputs plus hand-derived totals: pulses emitted, final index, busy cycles.
    typedef struct {
        int d;
        int w;
        int g;
        int c;
        int n_pulses;
        int last_idx;
        int n_busy;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string nm, input exp_t e);
        n_checks++;
        if (int'(pulse_out) != e.pulse || int'(busy) != e.busy || int'(done) != e.done
            || int'(pulse_idx) != e.idx) begin
            n_errors++;
            $display("FAIL %s @%0t: got pulse=%0d busy=%0d done=%0d idx=%0d, want pulse=%0d busy=%0d done=%0d idx=%0d",
                     nm, $time, pulse_out, busy, done, pulse_idx, e.pulse, e.busy, e.done, e.idx);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    function automatic exp_t mk(input int p, input int b, input int d, input int i);
        exp_t e;
        e.pulse = p;
        e.busy  = b;
        e.done  = d;
        e.idx   = i;
        return e;
    endfunction

    // Expected per-cycle waveform for one sequence, starting the cycle after start is sampled.
    task automatic build_expected(input vec_t v);
        int gl;
        gl = (v.g == 0) ? 1 : v.g;
        if (v.w == 0 || v.c == 0) begin
            sb_q.push_back(mk(0, 1, 1, 0));
            sb_q.push_back(mk(0, 0, 0, 0));
        end else begin
            for (int i = 0; i < v.d; i++) sb_q.push_back(mk(0, 1, 0, 0));
            for (int p = 0; p < v.c; p++) begin
                for (int i = 0; i < v.w; i++) sb_q.push_back(mk(1, 1, 0, p));
                if (p < v.c - 1) begin
                    for (int i = 0; i < gl; i++) sb_q.push_back(mk(0, 1, 0, p));
                end
            end
            sb_q.push_back(mk(0, 1, 1, v.c - 1));
            sb_q.push_back(mk(0, 0, 0, v.c - 1));
        end
    endtask

    task automatic drive_start(input int d, input int w, input int g, input int c);
        @(negedge clk_in);
        cfg_delay = W'(d);
        cfg_width = W'(w);
        cfg_gap   = W'(g);
        cfg_count = W'(c);
        start     = 1'b1;
        @(posedge clk_in);
        #1;
        start = 1'b0;
    endtask

    // Run one sequence; with disturb, re-request start and scramble cfg while busy.
    task automatic run_vector(input string nm, input vec_t v, input bit disturb);
        exp_t e;
        int   pulses, busy_cycles, prev;
        build_expected(v);
        drive_start(v.d, v.w, v.g, v.c);
        pulses = 0;
        busy_cycles = 0;
        prev = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk_in);
            e = sb_q.pop_front();
            check(nm, e);
            if (pulse_out && prev == 0) pulses++;
            prev = int'(pulse_out);
            if (busy) busy_cycles++;
            if (disturb && sb_q.size() > 0) begin
                start     = 1'b1;
                cfg_width = W'($urandom_range(1, 15));
                cfg_gap   = W'($urandom_range(0, 15));
                cfg_count = W'($urandom_range(1, 15));
                cfg_delay = W'($urandom_range(0, 15));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check_int({nm, " pulses"}, pulses, v.n_pulses);
        check_int({nm, " busy_cycles"}, busy_cycles, v.n_busy);
        check_int({nm, " final_idx"}, int'(pulse_idx), v.last_idx);
    endtask

    function automatic vec_t mkv(input int d, input int w, input int g, input int c,
                                 input int np, input int li, input int nb);
        vec_t v;
        v.d = d; v.w = w; v.g = g; v.c = c;
        v.n_pulses = np; v.last_idx = li; v.n_busy = nb;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t va;
        vecs.push_back(mkv(3, 4, 2, 3, 3, 2, 20));
        vecs.push_back(mkv(0, 1, 0, 2, 2, 1, 4));
        vecs.push_back(mkv(1, 2, 1, 1, 1, 0, 4));
        vecs.push_back(mkv(2, 0, 3, 2, 0, 0, 1));
`ifndef PULSE_SEQ_FREERUN_EN
        vecs.push_back(mkv(1, 1, 1, 0, 0, 0, 1));
`endif
        vecs.push_back(mkv(5, 3, 0, 4, 4, 3, 21));
        vecs.push_back(mkv(0, 15, 15, 1, 1, 0, 16));
        vecs.push_back(mkv(15, 15, 15, 15, 15, 14, 451));

        // Reset state.
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("reset", mk(0, 0, 0, 0));
        rst = 1'b0;
        @(negedge clk_in);
        check("idle_after_reset", mk(0, 0, 0, 0));

        // Table-driven sequences.
        for (int i = 0; i < vecs.size(); i++) begin
            run_vector($sformatf("vec%0d", i), vecs[i], 1'b0);
        end

        // Abort in the 2nd HIGH cycle of pulse 1 (cycle 9 after start).
        drive_start(1, 4, 2, 3);
        repeat (8) @(negedge clk_in);
        @(negedge clk_in);
        check("abort_pre", mk(1, 1, 0, 1));
        abort = 1'b1;
        @(negedge clk_in);
        check("abort_next", mk(0, 0, 0, 1));
        abort = 1'b0;
        repeat (3) begin
            @(negedge clk_in);
            check("abort_no_done", mk(0, 0, 0, 1));
        end
        va = mkv(3, 4, 2, 3, 3, 2, 20);
        run_vector("after_abort", va, 1'b0);

        // Start repeated while busy with cfg changed: original run unaffected.
        va = mkv(0, 3, 1, 2, 2, 1, 8);
        run_vector("restart_ignored", va, 1'b1);

        // Start and abort together in IDLE: stays idle.
        @(negedge clk_in);
        cfg_delay = 4'd0; cfg_width = 4'd2; cfg_gap = 4'd1; cfg_count = 4'd2;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", mk(0, 0, 0, 1));
        repeat (2) begin
            @(negedge clk_in);
            check("start_abort_stay", mk(0, 0, 0, 1));
        end

        // Reset in the second GAP (cycle 9 after start).
        drive_start(0, 2, 3, 3);
        repeat (8) @(negedge clk_in);
        @(negedge clk_in);
        check("rst_pre_gap", mk(0, 1, 0, 1));
        rst = 1'b1;
        @(negedge clk_in);
        check("rst_mid_gap", mk(0, 0, 0, 0));
        rst = 1'b0;
        @(negedge clk_in);
        check("rst_idle", mk(0, 0, 0, 0));
        va = mkv(2, 1, 0, 2, 2, 1, 6);
        run_vector("after_rst", va, 1'b0);

`ifdef PULSE_SEQ_FREERUN_EN
        // Free-running: alternating pulses, index wraps modulo 16, stopped by abort.
        for (int k = 1; k <= 40; k++) sb_q.push_back(mk(k % 2, 1, 0, ((k - 1) / 2) % 16));
        drive_start(0, 1, 1, 0);
        while (sb_q.size() > 0) begin
            @(negedge clk_in);
            check("freerun", sb_q.pop_front());
        end
        abort = 1'b1;
        @(negedge clk_in);
        abort = 1'b0;
        check("freerun_abort", mk(0, 0, 0, 3));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pulse_sequencer.md
PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of every timing field, the repetition count and the pulse index.
REQ-002 clk_in  input  1  single clock; all logic on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to run a sequence; sampled only in IDLE.
REQ-005 abort  input  1  level; terminates any active sequence.
REQ-006 cfg_delay  input  CNT_WIDTH  cycles from start to first pulse.
REQ-007 cfg_width  input  CNT_WIDTH  cycles each pulse is high.
REQ-008 cfg_gap  input  CNT_WIDTH  low cycles between consecutive pulses.
REQ-009 cfg_count  input  CNT_WIDTH  number of pulses per sequence.
REQ-010 pulse_out  output  1  registered stretched pulse train.
REQ-011 busy  output  1  high from the cycle after start is accepted through the DONE cycle.
REQ-012 done  output  1  one-cycle strobe on normal completion.
REQ-013 pulse_idx  output  CNT_WIDTH  zero-based index of the current or most recent pulse.

Function
REQ-014 FSM states: IDLE, DELAY, HIGH, GAP, DONE.
REQ-015 IDLE with start=1 and abort=0 latches all cfg_* inputs; the sequence uses only the latched values.
REQ-016 cfg_* changes during a sequence have no effect.
REQ-017 IDLE transitions to DELAY if latched delay>0, else to HIGH.
REQ-018 DELAY lasts exactly cfg_delay cycles.
REQ-019 Rising edge of pulse_out is cfg_delay+1 cycles after the start-sampling edge.
REQ-020 HIGH lasts exactly cfg_width cycles with pulse_out=1; pulse_out=0 in all other states.
REQ-021 After HIGH, go to GAP if pulses remain, else to DONE; no trailing gap after the last pulse.
REQ-022 GAP lasts max(cfg_gap,1) cycles; gap=0 is treated as 1 so pulses stay distinct.
REQ-023 pulse_idx resets to 0 at start acceptance and increments on each GAP-to-HIGH transition.
REQ-024 DONE lasts one cycle with done=1 and busy=1, then returns to IDLE.
REQ-025 Latched width=0: go directly to DONE with no pulse.
REQ-026 Latched count=0: behaviour per REQ-033/REQ-034.
REQ-027 start while busy is ignored.
REQ-028 abort in any non-IDLE state forces IDLE on the next edge; pulse_out=0 and busy=0 there; done is not asserted.
REQ-029 abort has priority over start in the same cycle.
REQ-030 All counters are CNT_WIDTH bits; maximum values (all ones) are legal, with no wrap or early exit.

Reset
REQ-031 rst=1 at an edge forces IDLE, pulse_out=0, busy=0, done=0, pulse_idx=0, and clears latched config; this holds mid-sequence.
REQ-032 No output is combinational from any input.

Configuration
REQ-033 Macro PULSE_SEQ_FREERUN_EN defined: latched count=0 means run pulses indefinitely until abort or rst; pulse_idx wraps modulo 2^CNT_WIDTH; done is never asserted.
REQ-034 Macro PULSE_SEQ_FREERUN_EN undefined: latched count=0 goes directly to DONE with no pulse.

Structure
REQ-035 Package pulse_seq_pkg holds the state enumeration and the default CNT_WIDTH constant.
REQ-036 One sub-module, seq_down_counter: loadable down-counter with a zero flag, reused for delay, width, gap and remaining-count timing.

Verification
REQ-037 delay=3, width=4, gap=2, count=3 -> pulse_out rises 4 cycles after start, pulses 4 high / 2 low x3, done 1 cycle after last fall, pulse_idx ends at 2.
REQ-038 delay=0, width=1, gap=0, count=2 -> pulse_out high the cycle after start, low 1 cycle, high 1 cycle, then done.
REQ-039 abort asserted in 2nd HIGH cycle of pulse 1 -> pulse_out=0 and busy=0 the next cycle, no done; a fresh start is then accepted.
REQ-040 start repeated while busy, with cfg_width changed mid-run -> no restart, original width kept; start and abort together in IDLE -> stays IDLE.
REQ-041 count=0 -> without macro: done the cycle after DONE entry, no pulse; with macro: continuous pulses until abort.
REQ-042 rst asserted mid-GAP -> all outputs at reset values the next cycle.
